adc_spi_emulator: RTL and testbench

Serial-ADC emulator: the transmitting end of the chip-select / SPI-clock / data link the acquisition front end uses to read its four ADCs. It oversamples an externally driven `cs_n_in` and `spi_clk_in` on the 100 MHz system clock and shifts out 16-bit ADC-format frames on `sdo`. One instance per emulated channel sits on a loopback Pmod, so the capture chain, AXI master and UART path can be exercised without analog hardware.

---
 rtl/adc_emu_pkg.sv | 15 +
 rtl/adc_spi_emulator_sync_edge.sv | 45 ++++
 rtl/adc_spi_emulator.sv | 178 +++++++++++++++++
 tb/tb_adc_spi_emulator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_emu_pkg.sv
// Shared definitions for the serial-ADC emulator: default frame geometry
// and the frame FSM state type.
package adc_emu_pkg;

  localparam int unsigned ADC_DATA_W     = 12;
  localparam int unsigned ADC_LEAD_ZEROS = 4;
  localparam int unsigned ADC_FRAME_W    = ADC_DATA_W + ADC_LEAD_ZEROS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TRAIL = 2'd2
  } adc_emu_state_t;

endpackage

// File: rtl/adc_spi_emulator_sync_edge.sv
// sync_edge: STAGES-deep synchronizer for an asynchronous level, with
// registered one-cycle rise/fall pulses aligned to the last sync stage.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic [STAGES:0]   w_chain;
  logic              w_next;
  logic              w_last;
  logic              r_rise;
  logic              r_fall;

  // w_next is the value the last stage takes on this edge, so the pulse is
  // registered together with it and adds no cycle of latency.
  always_comb begin
    w_chain = {r_sync, i_d};
    w_next  = w_chain[STAGES-1];
    w_last  = w_chain[STAGES];
  end

  // Synchronizer chain and edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= w_chain[STAGES-1:0];
      r_rise <= w_next & ~w_last;
      r_fall <= ~w_next & w_last;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/adc_spi_emulator.sv
// adc_spi_emulator: transmitting end of the CS/SCLK/SDO ADC link. Samples
// cs_n_in and spi_clk_in on clk and shifts {LEAD_ZEROS zeros, sample} out
// MSB first, changing sdo after each spi_clk falling edge.
// Build option: define ADC_EMU_RAMP_EN to use an internal ramp as the
// fallback sample when the holding register is empty (otherwise the last
// transmitted sample is repeated).
module adc_spi_emulator
  import adc_emu_pkg::*;
#(
  parameter int unsigned DATA_W      = ADC_DATA_W,
  parameter int unsigned LEAD_ZEROS  = ADC_LEAD_ZEROS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk_in,
  input  logic              cs_n_in,
  output logic              sdo,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              frame_done,
  output logic              frame_abort,
  output logic [15:0]       frame_count
);

  localparam int unsigned FRAME_W = LEAD_ZEROS + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

  logic w_cs_rise;
  logic w_cs_fall;
  logic w_sclk_rise;
  logic w_sclk_fall;

  adc_emu_state_t      r_state;
  logic [FRAME_W-1:0]  r_shreg;
  logic [CNT_W-1:0]    r_bitcnt;
  logic                r_frame_done;
  logic                r_frame_abort;
  logic [15:0]         r_frame_count;
  logic [DATA_W-1:0]   r_hold;
  logic                r_hold_full;
  logic [DATA_W-1:0]   w_sample;
  logic [DATA_W-1:0]   w_fallback;
  logic                w_xfer;
  logic                w_start;

  // cs_n sync resets low so a reset released mid-frame (cs_n still low)
  // does not see a fresh fall and restart the frame.
  sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (cs_n_in),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (spi_clk_in),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // Handshake and frame-start decode; the start uses the pre-transfer hold state.
  always_comb begin
    w_xfer   = s_valid & ~r_hold_full;
    w_start  = (r_state == IDLE) & w_cs_fall;
    w_sample = r_hold_full ? r_hold : w_fallback;
  end

  // Holding register: filled by the handshake, emptied by a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_hold <= s_data;
      end
      r_hold_full <= (r_hold_full & ~w_start) | w_xfer;
    end
  end

`ifdef ADC_EMU_RAMP_EN
  logic [DATA_W-1:0] r_ramp;

  // Ramp advances only when a frame actually consumed it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ramp <= '0;
    end else if (w_start && !r_hold_full) begin
      r_ramp <= r_ramp + 1'b1;
    end
  end

  assign w_fallback = r_ramp;
`else
  logic [DATA_W-1:0] r_last_sample;

  // Remember every sample loaded so an empty holding register repeats it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_sample <= '0;
    end else if (w_start) begin
      r_last_sample <= w_sample;
    end
  end

  assign w_fallback = r_last_sample;
`endif

  // Frame FSM: cs_n rise takes priority over an spi_clk fall in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_shreg       <= '0;
      r_bitcnt      <= '0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_shreg  <= FRAME_W'(w_sample);
            r_bitcnt <= '0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_cs_rise) begin
            r_frame_abort <= 1'b1;
            r_state       <= IDLE;
          end else if (w_sclk_fall) begin
            r_shreg  <= r_shreg << 1;
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == CNT_W'(FRAME_W - 1)) begin
              r_state <= TRAIL;
            end
          end
        end
        TRAIL: begin
          if (w_cs_rise) begin
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 1'b1;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Serial output is only driven while shifting.
  always_comb begin
    sdo = (r_state == SHIFT) ? r_shreg[FRAME_W-1] : 1'b0;
  end

  // spi_clk rising edges are not needed: the reader samples on them.
  logic w_unused;
  assign w_unused = w_sclk_rise;

  assign s_ready     = ~r_hold_full;
  assign frame_done  = r_frame_done;
  assign frame_abort = r_frame_abort;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_adc_spi_emulator.sv
// Bench for adc_spi_emulator: acts as the SPI reader (CPOL 0, samples on
// spi_clk rise) and compares against a frame-level model of the emulator.
module tb_adc_spi_emulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_clk_in;
  logic        cs_n_in;
  logic        sdo;
  logic [11:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        frame_done;
  logic        frame_abort;
  logic [15:0] frame_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          done_cnt = 0;
  int          abort_cnt = 0;

  // model state
  logic [11:0] m_hold;
  logic        m_full;
  logic [11:0] m_ramp;
  logic [11:0] m_last;
  logic [15:0] m_count;

  adc_spi_emulator #(
    .DATA_W      (12),
    .LEAD_ZEROS  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_clk_in  (spi_clk_in),
    .cs_n_in     (cs_n_in),
    .sdo         (sdo),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1)  done_cnt++;
    if (frame_abort === 1'b1) abort_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hold  = '0;
    m_full  = 1'b0;
    m_ramp  = '0;
    m_last  = '0;
    m_count = '0;
  endtask

  // Sample chosen at frame start: queued data if any, otherwise the fallback.
  task automatic model_take(output logic [15:0] frame);
    logic [11:0] smp;
    if (m_full) begin
      smp    = m_hold;
      m_full = 1'b0;
    end else begin
`ifdef ADC_EMU_RAMP_EN
      smp    = m_ramp;
      m_ramp = m_ramp + 12'd1;
`else
      smp    = m_last;
`endif
    end
    m_last = smp;
    frame  = {4'h0, smp};
  endtask

  task automatic write_sample(input logic [11:0] d);
    check("ready_pre", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    s_valid = 1'b0;
    m_hold  = d;
    m_full  = 1'b1;
    check("ready_post", {31'd0, s_ready}, 32'd0);
  endtask

  // One reader transaction of nbits clocks (16 = complete frame).
  task automatic do_frame(input int nbits, input int half, input bit coll, input logic [11:0] cdata);
    logic [15:0] exp;
    logic [15:0] cap;
    int d0, a0;
    bool_dummy: begin end
    cap = '0;
    d0  = done_cnt;
    a0  = abort_cnt;
    check("idle_sdo", {31'd0, sdo}, 32'd0);
    @(negedge clk);
    cs_n_in = 1'b0;
    model_take(exp);
    if (coll) begin
      repeat (2) @(negedge clk);
      s_valid = 1'b1;
      s_data  = cdata;
      @(negedge clk);
      s_valid = 1'b0;
      m_hold  = cdata;
      m_full  = 1'b1;
      repeat (half - 3) @(negedge clk);
    end else begin
      repeat (half) @(negedge clk);
    end
    for (int i = 0; i < nbits; i++) begin
      cap = {cap[14:0], sdo};
      spi_clk_in = 1'b1;
      repeat (half) @(negedge clk);
      spi_clk_in = 1'b0;
      repeat (half) @(negedge clk);
    end
    if (nbits == 16) begin
      check("trail_sdo", {31'd0, sdo}, 32'd0);
      check("frame_data", {16'd0, cap}, {16'd0, exp});
    end else begin
      check("abort_data", {16'd0, cap}, {16'd0, exp >> (16 - nbits)});
    end
    cs_n_in = 1'b1;
    repeat (2) @(negedge clk);
    check("pulse_early", {30'd0, frame_done, frame_abort}, 32'd0);
    @(negedge clk);
    check("pulse_at_3", {30'd0, frame_done, frame_abort}, (nbits == 16) ? 32'd2 : 32'd1);
    repeat (5) @(negedge clk);
    if (nbits == 16) m_count = m_count + 16'd1;
    check("done_cnt", done_cnt - d0, (nbits == 16) ? 32'd1 : 32'd0);
    check("abort_cnt", abort_cnt - a0, (nbits == 16) ? 32'd0 : 32'd1);
    check("frame_count", {16'd0, frame_count}, {16'd0, m_count});
    check("s_ready", {31'd0, s_ready}, {31'd0, ~m_full});
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, a0;
    rst_n      = 1'b0;
    cs_n_in    = 1'b1;
    spi_clk_in = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst_sdo", {31'd0, sdo}, 32'd0);
    check("rst_ready", {31'd0, s_ready}, 32'd1);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_abort", {31'd0, frame_abort}, 32'd0);
    check("rst_count", {16'd0, frame_count}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // normal frame
    write_sample(12'hA5C);
    do_frame(16, 5, 1'b0, '0);

    // known sample followed by empty-holding-register frames
    write_sample(12'h123);
    do_frame(16, 5, 1'b0, '0);
    do_frame(16, 5, 1'b0, '0);
    do_frame(16, 5, 1'b0, '0);

    // abort after 9 clocks, then a good frame
    write_sample(12'h3C7);
    do_frame(9, 5, 1'b0, '0);
    write_sample(12'h5E1);
    do_frame(16, 5, 1'b0, '0);

    // reset in the middle of a frame
    write_sample(12'hBEE);
    @(negedge clk);
    cs_n_in = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      spi_clk_in = 1'b1;
      repeat (5) @(negedge clk);
      spi_clk_in = 1'b0;
      repeat (5) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    d0 = done_cnt;
    a0 = abort_cnt;
    for (int i = 0; i < 11; i++) begin
      check("rst_mid_sdo", {31'd0, sdo}, 32'd0);
      spi_clk_in = 1'b1;
      repeat (5) @(negedge clk);
      spi_clk_in = 1'b0;
      repeat (5) @(negedge clk);
    end
    cs_n_in = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_mid_pulses", (done_cnt - d0) + (abort_cnt - a0), 32'd0);
    check("rst_mid_count", {16'd0, frame_count}, 32'd0);
    do_frame(16, 5, 1'b0, '0);
    write_sample(12'h9A4);
    do_frame(16, 4, 1'b0, '0);

    // counter wrap with a same-cycle s_valid / cs_n fall collision
    force dut.r_frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_count;
    m_count = 16'hFFFF;
    @(negedge clk);
    check("count_preload", {16'd0, frame_count}, 32'h0000FFFF);
    do_frame(16, 5, 1'b1, 12'h7D2);
    do_frame(16, 5, 1'b0, '0);

    // randomized traffic
    for (int n = 0; n < 20; n++) begin
      int nb;
      if (!m_full && $urandom_range(0, 1) == 1) write_sample(12'($urandom_range(0, 4095)));
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 16;
      do_frame(nb, int'($urandom_range(4, 7)), 1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
